// File: rtl/sc_datamem_mmio.sv
// sc_datamem_mmio: single-cycle data memory with memory-mapped I/O.
//
// Purpose
//   Byte-addressed 32-bit data RAM (2^AW words) plus an I/O window selected
//   by addr[IO_BIT]. I/O indices 0..N_IN-1 read the synchronized input
//   ports. Indices N_IN..N_IN+N_OUT-1 read back the output registers.
//   I/O writes to index k < N_OUT load output register k. One access is
//   accepted per cycle. Read data and the status pulses are registered, so
//   they appear in the cycle after the request edge.
//
// Ports
//   clock     rising-edge clock for all state
//   reset     synchronous, active-high reset (RAM contents are kept)
//   req       access request, sampled every rising edge
//   we        1 = write, 0 = read
//   size      00 byte, 01 half, 10 word, 11 illegal
//   addr      byte address; bits above IO_BIT are ignored
//   datain    right-justified write data
//   dataout   zero-extended read data, held while rvalid = 0
//   rvalid    one-cycle pulse: dataout carries a fresh read result
//   err       one-cycle pulse: the access was rejected
//   out_port  N_OUT output registers, port k at [32k+31:32k]
//   in_port   N_IN asynchronous inputs, packed the same way
module sc_datamem_mmio #(
    parameter int AW     = 5,
    parameter int N_OUT  = 3,
    parameter int N_IN   = 2,
    parameter int IO_BIT = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [1:0]           size,
    input  logic [31:0]          addr,
    input  logic [31:0]          datain,
    output logic [31:0]          dataout,
    output logic                 rvalid,
    output logic                 err,
    output logic [32*N_OUT-1:0]  out_port,
    input  logic [32*N_IN-1:0]   in_port
);

    localparam int IO_W = IO_BIT - 2;

    logic [31:0]         mem_r [2**AW];
    logic [31:0]         out_r [N_OUT];
    logic [32*N_IN-1:0]  sync1_r;
    logic [32*N_IN-1:0]  sync2_r;
    logic [31:0]         dataout_r;
    logic                rvalid_r;
    logic                err_r;

    logic                is_io_s;
    logic                reject_s;
    logic                accept_s;
    logic                rd_acc_s;
    logic                wr_acc_s;
    logic [AW-1:0]       ram_idx_s;
    logic [31:0]         io_idx_s;
    logic [3:0]          lane_en_s;
    logic [31:0]         wdata_s;
    logic [31:0]         ram_word_s;
    logic [31:0]         ram_shift_s;
    logic [31:0]         ram_rd_s;
    logic [31:0]         io_rd_s;
    logic [31:0]         rd_data_s;
    logic                unused_addr_s;

    // Address bits above the I/O select bit take no part in decoding.
    assign unused_addr_s = ^addr[31:IO_BIT+1];

    // Decode the request.
    // Alignment and size legality are checked here.
    // The I/O window only accepts word accesses.
    always_comb begin
        is_io_s   = addr[IO_BIT];
        ram_idx_s = addr[AW+1:2];
        io_idx_s  = {{(32-IO_W){1'b0}}, addr[IO_BIT-1:2]};
        reject_s  = 1'b1;
        case (size)
            2'b00:   reject_s = is_io_s;
            2'b01:   reject_s = is_io_s | addr[0];
            2'b10:   reject_s = (addr[1:0] != 2'b00);
            default: reject_s = 1'b1;
        endcase
        accept_s = req & ~reject_s;
        rd_acc_s = accept_s & ~we;
        wr_acc_s = accept_s & we;
    end

    // Select the write byte lanes (little-endian).
    // Replicate the write data so each lane sees its slice.
    always_comb begin
        lane_en_s = 4'b0000;
        wdata_s   = 32'h0000_0000;
        case (size)
            2'b00: begin
                lane_en_s = 4'b0001 << addr[1:0];
                wdata_s   = {4{datain[7:0]}};
            end
            2'b01: begin
                lane_en_s = addr[1] ? 4'b1100 : 4'b0011;
                wdata_s   = {2{datain[15:0]}};
            end
            2'b10: begin
                lane_en_s = 4'b1111;
                wdata_s   = datain;
            end
            default: begin
                lane_en_s = 4'b0000;
                wdata_s   = 32'h0000_0000;
            end
        endcase
    end

    // Form the read data.
    // RAM bytes and halves are shifted down to bit 0 and zero-extended.
    // The I/O read is a match-OR over the indices, so an unmapped index
    // reads as zero.
    always_comb begin
        ram_word_s  = mem_r[ram_idx_s];
        ram_shift_s = ram_word_s >> {addr[1:0], 3'b000};
        ram_rd_s    = 32'h0000_0000;
        case (size)
            2'b00:   ram_rd_s = {24'h00_0000, ram_shift_s[7:0]};
            2'b01:   ram_rd_s = {16'h0000, ram_shift_s[15:0]};
            2'b10:   ram_rd_s = ram_word_s;
            default: ram_rd_s = 32'h0000_0000;
        endcase
        io_rd_s = 32'h0000_0000;
        for (int k = 0; k < N_IN; k++) begin
            io_rd_s = io_rd_s | ((io_idx_s == 32'(k)) ? sync2_r[32*k +: 32] : 32'h0000_0000);
        end
        for (int k = 0; k < N_OUT; k++) begin
            io_rd_s = io_rd_s | ((io_idx_s == 32'(N_IN + k)) ? out_r[k] : 32'h0000_0000);
        end
        rd_data_s = is_io_s ? io_rd_s : ram_rd_s;
    end

    // Two-flop synchronizer for the asynchronous input ports.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= in_port;
            sync2_r <= sync1_r;
        end
    end

    // Registered read result, status pulses and output port registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            dataout_r <= 32'h0000_0000;
            rvalid_r  <= 1'b0;
            err_r     <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                out_r[k] <= 32'h0000_0000;
            end
        end else begin
            rvalid_r <= rd_acc_s;
            err_r    <= req & reject_s;
            if (rd_acc_s) begin
                dataout_r <= rd_data_s;
            end
            for (int k = 0; k < N_OUT; k++) begin
                if (wr_acc_s && is_io_s && (io_idx_s == 32'(k))) begin
                    out_r[k] <= datain;
                end
            end
        end
    end

    // Byte-lane RAM write.
    // There is no reset clear: reset only blocks the write.
    always_ff @(posedge clock) begin
        if (!reset && wr_acc_s && !is_io_s) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en_s[i]) begin
                    mem_r[ram_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign out_port[32*g +: 32] = out_r[g];
    end

    assign dataout = dataout_r;
    assign rvalid  = rvalid_r;
    assign err     = err_r;

endmodule

// File: tb/tb_sc_datamem_mmio.sv
module tb_sc_datamem_mmio;

    localparam int AW     = 5;
    localparam int N_OUT  = 3;
    localparam int N_IN   = 2;
    localparam int IO_BIT = 7;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 req;
    logic                 we;
    logic [1:0]           size;
    logic [31:0]          addr;
    logic [31:0]          datain;
    logic [31:0]          dataout;
    logic                 rvalid;
    logic                 err;
    logic [32*N_OUT-1:0]  out_port;
    logic [32*N_IN-1:0]   in_port;

    sc_datamem_mmio #(.AW(AW), .N_OUT(N_OUT), .N_IN(N_IN), .IO_BIT(IO_BIT)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .size(size),
        .addr(addr), .datain(datain), .dataout(dataout), .rvalid(rvalid),
        .err(err), .out_port(out_port), .in_port(in_port)
    );

    always #5 clock = ~clock;

    // Reference model: byte-array memory, port arrays, expected outputs.
    logic [7:0]  memb [4*(2**AW)];
    logic [31:0] outm [N_OUT];
    logic [31:0] inm  [N_IN];
    logic        exp_err;
    logic        exp_rvalid;
    logic [31:0] exp_dout;
    int          checks   = 0;
    int          failures = 0;

    function automatic void model_access(logic w, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
        bit io;
        int k;
        int ba;
        int n;
        bit bad;
        io  = a[IO_BIT];
        k   = int'(a[IO_BIT-1:2]);
        ba  = int'(a[AW+1:0]);
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        bad = (sz == 2'd3) || ((ba % n) != 0) || (io && sz != 2'd2);
        exp_err    = bad;
        exp_rvalid = !bad && !w;
        if (bad) return;
        if (w) begin
            if (io) begin
                if (k < N_OUT) outm[k] = d;
            end else begin
                for (int i = 0; i < n; i++) memb[ba+i] = d[8*i +: 8];
            end
        end else begin
            if (io) begin
                if (k < N_IN) exp_dout = inm[k];
                else if (k < N_IN + N_OUT) exp_dout = outm[k-N_IN];
                else exp_dout = 32'h0;
            end else begin
                exp_dout = 32'h0;
                for (int i = 0; i < n; i++) exp_dout[8*i +: 8] = memb[ba+i];
            end
        end
    endfunction

    // One request cycle: drive at negedge, update model, settle #1 after edge.
    task automatic drive(input logic rs, input logic r, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        reset = rs; req = r; we = w; size = sz; addr = a; datain = d;
        if (rs) begin
            for (int k = 0; k < N_OUT; k++) outm[k] = 32'h0;
            exp_dout = 32'h0; exp_err = 1'b0; exp_rvalid = 1'b0;
        end else if (r) begin
            model_access(w, sz, a, d);
        end else begin
            exp_err = 1'b0; exp_rvalid = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 2'd2, 32'h80, 32'h1111_2222);
        drive(1'b1, 1'b1, 1'b1, 2'd2, 32'h84, 32'h3333_4444);
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (dataout !== 32'h0) begin failures++; $display("FAIL reset_dataout got=%h exp=0", dataout); end
        checks++; if (out_port !== '0) begin failures++; $display("FAIL reset_out_port got=%h exp=0", out_port); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 2**AW; i++) begin
            drive(1'b0, 1'b1, 1'b1, 2'd2, 32'(i*4), $urandom);
            checks++;
            if (err !== 1'b0 || rvalid !== 1'b0) begin
                failures++; $display("FAIL fill_status i=%0d got err=%b rvalid=%b exp 0/0", i, err, rvalid);
            end
        end
    endtask

    task automatic test_directed();
        drive(1'b0, 1'b1, 1'b1, 2'd2, 32'h04, 32'hDEAD_BEEF);
        drive(1'b0, 1'b1, 1'b1, 2'd0, 32'h06, 32'h0000_0055);
        drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h04, 32'h0);
        checks++; if (rvalid !== 1'b1 || dataout !== 32'hDE55_BEEF) begin failures++; $display("FAIL word_read got=%b/%h exp=1/de55beef", rvalid, dataout); end
        drive(1'b0, 1'b1, 1'b0, 2'd1, 32'h06, 32'h0);
        checks++; if (rvalid !== 1'b1 || dataout !== 32'h0000_DE55) begin failures++; $display("FAIL half_read got=%b/%h exp=1/0000de55", rvalid, dataout); end
        drive(1'b0, 1'b1, 1'b0, 2'd1, 32'h05, 32'h0);
        checks++; if (err !== 1'b1 || rvalid !== 1'b0 || dataout !== 32'h0000_DE55) begin failures++; $display("FAIL half_misalign got err=%b rvalid=%b dout=%h exp 1/0/0000de55", err, rvalid, dataout); end
        drive(1'b0, 1'b1, 1'b1, 2'd2, 32'h88, 32'h1234_5678);
        checks++; if (out_port[95:64] !== 32'h1234_5678 || err !== 1'b0 || rvalid !== 1'b0) begin failures++; $display("FAIL io_write got=%h err=%b exp=12345678", out_port[95:64], err); end
        drive(1'b0, 1'b1, 1'b1, 2'd0, 32'h88, 32'h0000_00FF);
        checks++; if (err !== 1'b1 || out_port[95:64] !== 32'h1234_5678) begin failures++; $display("FAIL io_byte_write got err=%b port=%h exp 1/12345678", err, out_port[95:64]); end
        drive(1'b0, 1'b1, 1'b1, 2'd2, 32'h9C, 32'hFFFF_FFFF);
        checks++; if (err !== 1'b0 || out_port !== outm_packed()) begin failures++; $display("FAIL io_write_unmapped got err=%b ports=%h exp 0/%h", err, out_port, outm_packed()); end
        drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h90, 32'h0);
        checks++; if (rvalid !== 1'b1 || dataout !== 32'h1234_5678) begin failures++; $display("FAIL io_read_out got=%b/%h exp=1/12345678", rvalid, dataout); end
        drive(1'b0, 1'b1, 1'b0, 2'd2, 32'hFC, 32'h0);
        checks++; if (rvalid !== 1'b1 || dataout !== 32'h0) begin failures++; $display("FAIL io_read_high got=%b/%h exp=1/0", rvalid, dataout); end
        drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h04, 32'h0);
        checks++; if (dataout !== 32'hDE55_BEEF) begin failures++; $display("FAIL ram_unchanged got=%h exp=de55beef", dataout); end
    endtask

    function automatic logic [32*N_OUT-1:0] outm_packed();
        logic [32*N_OUT-1:0] p;
        for (int k = 0; k < N_OUT; k++) p[32*k +: 32] = outm[k];
        return p;
    endfunction

    task automatic test_inport();
        in_port[63:32] = 32'hA5A5_A5A5; inm[1] = 32'hA5A5_A5A5;
        drive(1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0);   // edge E
        drive(1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0);   // edge E+1
        drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h84, 32'h0);  // edge E+2
        checks++; if (rvalid !== 1'b1 || dataout !== 32'hA5A5_A5A5) begin failures++; $display("FAIL in_port_read got=%b/%h exp=1/a5a5a5a5", rvalid, dataout); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                a[IO_BIT] = 1'b0;
            end else begin
                a[IO_BIT] = 1'b1;
                a[6:2] = 5'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            r  = $urandom_range(0, 9);
            sz = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), sz, a, $urandom);
            checks++; if (err !== exp_err) begin failures++; $display("FAIL rand_err i=%0d a=%h sz=%0d got=%b exp=%b", i, a, sz, err, exp_err); end
            checks++; if (rvalid !== exp_rvalid) begin failures++; $display("FAIL rand_rvalid i=%0d a=%h sz=%0d got=%b exp=%b", i, a, sz, rvalid, exp_rvalid); end
            checks++; if (dataout !== exp_dout) begin failures++; $display("FAIL rand_dataout i=%0d a=%h sz=%0d got=%h exp=%h", i, a, sz, dataout, exp_dout); end
            checks++; if (out_port !== outm_packed()) begin failures++; $display("FAIL rand_out_port i=%0d got=%h exp=%h", i, out_port, outm_packed()); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] d;
        a = 32'($urandom_range(0, 2**AW - 1) * 4);
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            drive(1'b0, 1'b1, 1'b1, 2'd2, a, d);
            checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL b2b_write_rvalid i=%0d got=%b exp=0", i, rvalid); end
            drive(1'b0, 1'b1, 1'b0, 2'd2, a, 32'h0);
            checks++; if (rvalid !== 1'b1 || dataout !== d) begin failures++; $display("FAIL b2b_read i=%0d got=%b/%h exp=1/%h", i, rvalid, dataout, d); end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] d;
        d = $urandom;
        drive(1'b0, 1'b1, 1'b1, 2'd2, 32'h10, d);
        drive(1'b0, 1'b1, 1'b1, 2'd2, 32'h80, 32'h0BAD_0001);
        drive(1'b0, 1'b1, 1'b1, 2'd2, 32'h84, 32'h0BAD_0002);
        drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 2'd2, 32'h80, 32'hCAFE_F00D);
        checks++; if (rvalid !== 1'b0 || err !== 1'b0 || dataout !== 32'h0) begin failures++; $display("FAIL midreset_status got rvalid=%b err=%b dout=%h exp 0/0/0", rvalid, err, dataout); end
        checks++; if (out_port !== '0) begin failures++; $display("FAIL midreset_ports got=%h exp=0", out_port); end
        for (int k = 0; k < N_OUT; k++) begin
            drive(1'b0, 1'b1, 1'b0, 2'd2, 32'(32'h80 + 4*(N_IN + k)), 32'h0);
            checks++; if (rvalid !== 1'b1 || dataout !== 32'h0) begin failures++; $display("FAIL midreset_port_read k=%0d got=%b/%h exp=1/0", k, rvalid, dataout); end
        end
        drive(1'b0, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
        checks++; if (rvalid !== 1'b1 || dataout !== d) begin failures++; $display("FAIL midreset_ram got=%b/%h exp=1/%h", rvalid, dataout, d); end
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'd2; addr = 32'h0; datain = 32'h0;
        for (int k = 0; k < N_IN; k++) begin
            inm[k] = $urandom;
            in_port[32*k +: 32] = inm[k];
        end
        test_reset();
        test_fill();
        test_directed();
        test_inport();
        test_random();
        test_back_to_back();
        test_mid_reset();
        @(negedge clock);
        req = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
